// File: rtl/scan_muxdemux_if.sv
// Bus bundle for scan_muxdemux: channel inputs, serial link, status outputs.
// Suffixes follow the DUT's point of view (slave modport).
interface scan_muxdemux_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
);
  localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              en_i;
  logic              mode_i;
  logic [SEL_W-1:0]  sel_i;
  logic [N_CH*W-1:0] din_i;
  logic [W-1:0]      dmx_in_i;
  logic              dmx_vld_i;
  logic [W-1:0]      y_o;
  logic              y_valid_o;
  logic [SEL_W-1:0]  cur_sel_o;
  logic [N_CH*W-1:0] dout_o;
  logic [N_CH-1:0]   dout_stb_o;
  logic              wrap_o;

  modport master (
    output en_i, mode_i, sel_i, din_i, dmx_in_i, dmx_vld_i,
    input  y_o, y_valid_o, cur_sel_o, dout_o, dout_stb_o, wrap_o
  );

  modport slave (
    input  en_i, mode_i, sel_i, din_i, dmx_in_i, dmx_vld_i,
    output y_o, y_valid_o, cur_sel_o, dout_o, dout_stb_o, wrap_o
  );
endinterface

// File: rtl/scan_muxdemux.sv
// Registered N-channel time-division mux/demux with manual select or
// round-robin scan at a programmable dwell time.
module scan_muxdemux #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned DWELL = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  scan_muxdemux_if.slave bus
);
  localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  localparam logic [DW_W-1:0]  LAST_DW = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MAN = 2'd1, SCAN = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [W-1:0]      y_q, y_d;
  logic              y_valid_q, y_valid_d;
  logic [N_CH*W-1:0] dout_q, dout_d;
  logic [N_CH-1:0]   stb_q, stb_d;
  logic              wrap_q, wrap_d;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.en_i) state_d = bus.mode_i ? SCAN : MAN;
      MAN:     if (!bus.en_i) state_d = IDLE;
               else if (bus.mode_i) state_d = SCAN;
      SCAN:    if (!bus.en_i) state_d = IDLE;
               else if (!bus.mode_i) state_d = MAN;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; mux and demux act on the pre-edge channel
  always_comb begin
    cur_sel_d = cur_sel_q;
    dwell_d   = dwell_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    dout_d    = dout_q;
    stb_d     = '0;
    wrap_d    = 1'b0;

    if (state_q != IDLE) begin
      y_valid_d = 1'b1;
      for (int k = 0; k < N_CH; k++) begin
        if (cur_sel_q == SEL_W'(k)) begin
          y_d = bus.din_i[k*W +: W];
          if (bus.dmx_vld_i) begin
            dout_d[k*W +: W] = bus.dmx_in_i;
            stb_d[k]         = 1'b1;
          end
        end
      end
    end

    case (state_d)
      IDLE: dwell_d = '0;
      MAN: begin
        dwell_d = '0;
        if (32'(bus.sel_i) < N_CH) cur_sel_d = bus.sel_i;
      end
      SCAN: begin
        if (state_q == IDLE) begin
          cur_sel_d = '0;
          dwell_d   = '0;
        end else if (state_q == MAN) begin
          dwell_d = '0;
        end else if (dwell_q == LAST_DW) begin
          dwell_d = '0;
          if (cur_sel_q == LAST_CH) begin
            cur_sel_d = '0;
            wrap_d    = 1'b1;
          end else begin
            cur_sel_d = cur_sel_q + SEL_W'(1);
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      default: dwell_d = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_sel_q <= '0;
      dwell_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      dout_q    <= '0;
      stb_q     <= '0;
      wrap_q    <= 1'b0;
    end else begin
      cur_sel_q <= cur_sel_d;
      dwell_q   <= dwell_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      dout_q    <= dout_d;
      stb_q     <= stb_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.y_o        = y_q;
  assign bus.y_valid_o  = y_valid_q;
  assign bus.cur_sel_o  = cur_sel_q;
  assign bus.dout_o     = dout_q;
  assign bus.dout_stb_o = stb_q;
  assign bus.wrap_o     = wrap_q;
endmodule

// File: tb/tb_scan_muxdemux.sv
// Directed self-checking bench: default 4ch/DWELL=4 instance and a 3ch/DWELL=1 instance.
module tb_scan_muxdemux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  scan_muxdemux_if #(.N_CH(4), .W(8)) b0 ();
  scan_muxdemux_if #(.N_CH(3), .W(8)) b1 ();

  scan_muxdemux #(.N_CH(4), .W(8), .DWELL(4)) u0 (.clk_i(clk), .rst_i(rst), .bus(b0));
  scan_muxdemux #(.N_CH(3), .W(8), .DWELL(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1));

  typedef struct {
    logic       en;
    logic       mode;
    logic [1:0] sel;
    logic [1:0] exp_sel;
    logic [7:0] exp_y;
    logic       exp_yv;
  } man_vec_t;

  typedef struct {
    logic       en;
    logic       mode;
    logic [1:0] sel;
    logic [1:0] exp_sel;
    logic       exp_wrap;
  } n3_vec_t;

  man_vec_t mv[6];
  n3_vec_t  nv[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int k);
    return d[k*8 +: 8];
  endfunction

  function automatic int scan_sel(input int k);
    return ((k - 1) / 4) % 4;
  endfunction

  task automatic chk_u0_zero(input string tag);
    chk({tag, "_y"},       64'(b0.y_o),        64'h0);
    chk({tag, "_yv"},      64'(b0.y_valid_o),  64'h0);
    chk({tag, "_cur_sel"}, 64'(b0.cur_sel_o),  64'h0);
    chk({tag, "_dout"},    64'(b0.dout_o),     64'h0);
    chk({tag, "_stb"},     64'(b0.dout_stb_o), 64'h0);
    chk({tag, "_wrap"},    64'(b0.wrap_o),     64'h0);
  endtask

  initial begin
    logic [31:0] din0;
    logic [31:0] mdout;
    logic [3:0]  mstb;
    logic [7:0]  y_before;
    int          prev;

    b0.en_i = 0; b0.mode_i = 0; b0.sel_i = 0; b0.din_i = 32'hDDCCBBAA;
    b0.dmx_in_i = 0; b0.dmx_vld_i = 0;
    b1.en_i = 0; b1.mode_i = 0; b1.sel_i = 0; b1.din_i = 24'h332211;
    b1.dmx_in_i = 0; b1.dmx_vld_i = 0;

    mv[0] = '{1'b1, 1'b0, 2'd2, 2'd2, 8'h00, 1'b0};
    mv[1] = '{1'b1, 1'b0, 2'd2, 2'd2, 8'hCC, 1'b1};
    mv[2] = '{1'b1, 1'b0, 2'd0, 2'd0, 8'hCC, 1'b1};
    mv[3] = '{1'b1, 1'b0, 2'd0, 2'd0, 8'hAA, 1'b1};
    mv[4] = '{1'b0, 1'b0, 2'd0, 2'd0, 8'hAA, 1'b1};
    mv[5] = '{1'b0, 1'b0, 2'd0, 2'd0, 8'hAA, 1'b0};

    nv[0]  = '{1'b1, 1'b0, 2'd1, 2'd1, 1'b0};
    nv[1]  = '{1'b1, 1'b0, 2'd3, 2'd1, 1'b0};
    nv[2]  = '{1'b1, 1'b1, 2'd3, 2'd1, 1'b0};
    nv[3]  = '{1'b1, 1'b1, 2'd0, 2'd2, 1'b0};
    nv[4]  = '{1'b1, 1'b1, 2'd0, 2'd0, 1'b1};
    nv[5]  = '{1'b1, 1'b1, 2'd0, 2'd1, 1'b0};
    nv[6]  = '{1'b1, 1'b1, 2'd0, 2'd2, 1'b0};
    nv[7]  = '{1'b0, 1'b1, 2'd0, 2'd2, 1'b0};
    nv[8]  = '{1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
    nv[9]  = '{1'b1, 1'b1, 2'd0, 2'd1, 1'b0};
    nv[10] = '{1'b1, 1'b1, 2'd0, 2'd2, 1'b0};
    nv[11] = '{1'b1, 1'b1, 2'd0, 2'd0, 1'b1};

    // Power-on reset
    step(); step();
    chk_u0_zero("por");
    rst = 1'b0;

    // Manual select on the default instance
    for (int i = 0; i < 6; i++) begin
      b0.en_i = mv[i].en; b0.mode_i = mv[i].mode; b0.sel_i = mv[i].sel;
      step();
      chk($sformatf("man%0d_cur_sel", i), 64'(b0.cur_sel_o), 64'(mv[i].exp_sel));
      chk($sformatf("man%0d_y", i),       64'(b0.y_o),       64'(mv[i].exp_y));
      chk($sformatf("man%0d_yv", i),      64'(b0.y_valid_o), 64'(mv[i].exp_yv));
    end

    // Scan with demux writes for 16 active edges, then idle link
    din0 = 32'hD4C3B2A1;
    b0.din_i = din0; b0.en_i = 1; b0.mode_i = 1;
    mdout = 32'h0;
    for (int k = 1; k <= 33; k++) begin
      prev = (k >= 2) ? scan_sel(k - 1) : 0;
      b0.dmx_vld_i = (k >= 2 && k <= 17);
      b0.dmx_in_i  = 8'(8'h10 + k - 2);
      mstb = 4'h0;
      if (k >= 2 && k <= 17) begin
        mdout[prev*8 +: 8] = b0.dmx_in_i;
        mstb = 4'(1 << prev);
      end
      step();
      chk($sformatf("scan%0d_cur_sel", k), 64'(b0.cur_sel_o), 64'(scan_sel(k)));
      chk($sformatf("scan%0d_wrap", k), 64'(b0.wrap_o),
          64'((k > 1 && ((k - 1) % 16) == 0) ? 1 : 0));
      chk($sformatf("scan%0d_stb", k),  64'(b0.dout_stb_o), 64'(mstb));
      chk($sformatf("scan%0d_dout", k), 64'(b0.dout_o),     64'(mdout));
      if (k >= 2) begin
        chk($sformatf("scan%0d_y", k),  64'(b0.y_o),       64'(byte_of(din0, prev)));
        chk($sformatf("scan%0d_yv", k), 64'(b0.y_valid_o), 64'h1);
      end
    end
    chk("scan_dout_final", 64'(b0.dout_o), 64'h1F1B1713);

    // Three channels, single-cycle dwell
    for (int i = 0; i < 12; i++) begin
      b1.en_i = nv[i].en; b1.mode_i = nv[i].mode; b1.sel_i = nv[i].sel;
      step();
      chk($sformatf("n3_%0d_cur_sel", i), 64'(b1.cur_sel_o), 64'(nv[i].exp_sel));
      chk($sformatf("n3_%0d_wrap", i),    64'(b1.wrap_o),    64'(nv[i].exp_wrap));
    end
    b1.en_i = 0;

    // Async reset mid-scan, then restart at channel 0
    b0.en_i = 0; b0.dmx_vld_i = 0;
    step();
    b0.en_i = 1; b0.mode_i = 1; b0.dmx_vld_i = 1; b0.dmx_in_i = 8'h5A;
    for (int k = 0; k < 10; k++) step();
    chk("pre_rst_cur_sel", 64'(b0.cur_sel_o), 64'h2);
    y_before = b0.y_o;
    chk("pre_rst_y", 64'(y_before), 64'(byte_of(din0, 2)));
    #2 rst = 1'b1;
    #1 chk_u0_zero("async_rst");
    step(); step();
    chk_u0_zero("held_rst");
    #2 rst = 1'b0;
    b0.dmx_vld_i = 0;
    step();
    chk("rel1_cur_sel", 64'(b0.cur_sel_o), 64'h0);
    chk("rel1_yv",      64'(b0.y_valid_o), 64'h0);
    chk("rel1_y",       64'(b0.y_o),       64'h0);
    step();
    chk("rel2_y",  64'(b0.y_o),       64'(byte_of(din0, 0)));
    chk("rel2_yv", 64'(b0.y_valid_o), 64'h1);
    step(); step();
    chk("rel4_cur_sel", 64'(b0.cur_sel_o), 64'h0);
    step();
    chk("rel5_cur_sel", 64'(b0.cur_sel_o), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
